lsu_mem_if: RTL and testbench

- Load/store unit between the multicycle core's memory-phase control and a word-wide data-memory bus with a ready handshake.
- Sequences one load or store per request and generates byte enables and store-lane replication.
- Extracts and sign/zero-extends load data, and returns a one-cycle done pulse that the control FSM waits on before leaving its MEM state.
- Detects misaligned and illegal accesses without touching the bus.

---
 rtl/rv_lsu_pkg.sv | 17 +
 rtl/lsu_align.sv | 59 +++++
 rtl/lsu_mem_if.sv | 145 ++++++++++++++
 tb/tb_lsu_mem_if.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings and FSM states.
package rv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2,
    FAIL = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and replication, load extraction and
// extension, and misaligned/illegal access detection.
module lsu_align
  import rv_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] shifted;
  logic [3:0]  store_be;

  // Halfword accesses only pass the check with addr_lo[0]=0, so the shift lands on a half.
  assign shifted = bus_rdata >> {addr_lo, 3'b000};

  always_comb begin
    store_be   = 4'b1111;
    lane_wdata = wdata;
    load_data  = bus_rdata;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_B: begin
        store_be   = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        load_data  = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        store_be   = 4'b0011 << addr_lo;
        lane_wdata = {2{wdata[15:0]}};
        load_data  = {{16{shifted[15]}}, shifted[15:0]};
        misaligned = addr_lo[0];
      end
      F3_W: begin
        misaligned = |addr_lo;
      end
      F3_BU: begin
        load_data = {24'h0, shifted[7:0]};
        illegal   = is_store;
      end
      F3_HU: begin
        load_data  = {16'h0, shifted[15:0]};
        misaligned = addr_lo[0];
        illegal    = is_store;
      end
      default: illegal = 1'b1;
    endcase
    be = is_store ? store_be : 4'b1111;
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit between the core's MEM-phase control and a ready-handshake data bus.
// Optional bus-wait timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_if
  import rv_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_load,
  input  logic              start_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  if (ADDR_W < 3 || TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("lsu_mem_if: ADDR_W must be >= 3 and TIMEOUT_CYCLES in 1..65535");
  end

  lsu_state_e  state;
  logic [2:0]  f3_q;
  logic [1:0]  addr_lo_q;
  logic [2:0]  a_f3;
  logic [1:0]  a_addr_lo;
  logic        a_store;
  logic [3:0]  be;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;
  logic        misaligned;
  logic        illegal;

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;
`endif

  // In IDLE the checker sees the incoming request; afterwards it sees the latched access.
  always_comb begin
    a_f3      = f3_q;
    a_addr_lo = addr_lo_q;
    a_store   = bus_we;
    if (state == IDLE) begin
      a_f3      = funct3;
      a_addr_lo = addr[1:0];
      a_store   = start_store;
    end
  end

  lsu_align u_align (
    .funct3     (a_f3),
    .addr_lo    (a_addr_lo),
    .is_store   (a_store),
    .wdata      (wdata),
    .bus_rdata  (bus_rdata),
    .be         (be),
    .lane_wdata (lane_wdata),
    .load_data  (load_data),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      f3_q      <= 3'b000;
      addr_lo_q <= 2'b00;
      rdata     <= 32'h0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0;
`ifdef LSU_TIMEOUT_EN
      wait_cnt  <= 16'h0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_load || start_store) begin
            f3_q      <= funct3;
            addr_lo_q <= addr[1:0];
            bus_we    <= start_store;
            if (misaligned || illegal) begin
              state <= FAIL;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= BUS;
              busy      <= 1'b1;
              bus_req   <= 1'b1;
              bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
              bus_be    <= be;
              bus_wdata <= lane_wdata;
`ifdef LSU_TIMEOUT_EN
              wait_cnt  <= 16'h0;
`endif
            end
          end
        end
        BUS: begin
          if (bus_ready) begin
            if (!bus_we) rdata <= load_data;
            state   <= DONE;
            bus_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
`ifdef LSU_TIMEOUT_EN
          else if (wait_cnt == TimeoutLast) begin
            state   <= FAIL;
            bus_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        DONE:    state <= IDLE;
        FAIL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if; covers the timeout path when LSU_TIMEOUT_EN is defined.
module tb_lsu_mem_if;
  import rv_lsu_pkg::*;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TimeoutCycles = 4;
`else
  localparam int unsigned TimeoutCycles = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start_load, start_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        done, busy, err;
  logic        bus_req, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  lsu_mem_if #(
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_load  (start_load),
    .start_store (start_store),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .done        (done),
    .busy        (busy),
    .err         (err),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_ready   (bus_ready),
    .bus_rdata   (bus_rdata)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drives a one-cycle start; returns at the negedge of the first cycle after acceptance.
  task automatic launch(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    start_load  = ld;
    start_store = st;
    funct3      = f3;
    addr        = a;
    wdata       = wd;
    @(negedge clk);
    start_load  = 1'b0;
    start_store = 1'b0;
  endtask

  // Ready in the current request cycle; returns in the done cycle.
  task automatic zero_wait(input logic [31:0] rd);
    bus_ready = 1'b1;
    bus_rdata = rd;
    @(negedge clk);
    bus_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start_load = 1'b0; start_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;
    #2;
    check_vec("rst_rdata", rdata, 32'h0);
    check_vec("rst_ctl", {done, busy, err, bus_req, bus_we}, 32'h0);
    check_vec("rst_addr", bus_addr, 32'h0);
    check_vec("rst_be", {28'h0, bus_be}, 32'h0);
    check_vec("rst_wdata", bus_wdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // SW with both starts high: store wins, zero-wait ready.
    launch(1'b1, 1'b1, F3_W, 32'h104, 32'hDEADBEEF);
    check_vec("sw_req", bus_req, 32'h1);
    check_vec("sw_we", bus_we, 32'h1);
    check_vec("sw_addr", bus_addr, 32'h104);
    check_vec("sw_be", {28'h0, bus_be}, 32'hF);
    check_vec("sw_wdata", bus_wdata, 32'hDEADBEEF);
    check_vec("sw_busy", busy, 32'h1);
    check_vec("sw_nodone", done, 32'h0);
    zero_wait(32'h0);
    check_vec("sw_done", {done, err, bus_req, busy}, 32'h8);
    @(negedge clk);
    check_vec("sw_pulse", done, 32'h0);

    // SB at byte 3; a start during DONE must be ignored.
    launch(1'b0, 1'b1, F3_B, 32'h203, 32'h000000A5);
    check_vec("sb_be", {28'h0, bus_be}, 32'h8);
    check_vec("sb_wdata", bus_wdata, 32'hA5A5A5A5);
    check_vec("sb_addr", bus_addr, 32'h200);
    zero_wait(32'h0);
    check_vec("sb_done", done, 32'h1);
    launch(1'b0, 1'b1, F3_W, 32'h500, 32'h0);
    check_vec("ign_req", {bus_req, busy, done}, 32'h0);
    @(negedge clk);

    // SH upper half.
    launch(1'b0, 1'b1, F3_H, 32'h102, 32'h1234BEEF);
    check_vec("sh_be", {28'h0, bus_be}, 32'hC);
    check_vec("sh_wdata", bus_wdata, 32'hBEEFBEEF);
    zero_wait(32'h0);
    check_vec("sh_done", done, 32'h1);
    @(negedge clk);

    // LB then LBU at byte 2 of 0x11807F22.
    launch(1'b1, 1'b0, F3_B, 32'h202, 32'h0);
    check_vec("lb_ctl", {28'h0, bus_we, bus_be[2:0]}, 32'h7);
    check_vec("lb_be3", bus_be[3], 32'h1);
    check_vec("lb_addr", bus_addr, 32'h200);
    zero_wait(32'h11807F22);
    check_vec("lb_done", {done, err}, 32'h2);
    check_vec("lb_rdata", rdata, 32'hFFFFFF80);
    @(negedge clk);
    launch(1'b1, 1'b0, F3_BU, 32'h202, 32'h0);
    zero_wait(32'h11807F22);
    check_vec("lbu_rdata", rdata, 32'h00000080);
    @(negedge clk);

    // Misaligned LH: fails without bus activity, rdata untouched.
    launch(1'b1, 1'b0, F3_H, 32'h201, 32'h0);
    check_vec("lhmis_flags", {done, err, bus_req, busy}, 32'hC);
    check_vec("lhmis_rdata", rdata, 32'h00000080);
    @(negedge clk);
    check_vec("lhmis_pulse", {done, err, bus_req}, 32'h0);

    // Illegal store funct3 and misaligned SW.
    launch(1'b0, 1'b1, 3'b011, 32'h100, 32'h0);
    check_vec("ill_sw", {done, err, bus_req}, 32'h6);
    @(negedge clk);
    launch(1'b0, 1'b1, F3_W, 32'h102, 32'h0);
    check_vec("mis_sw", {done, err, bus_req}, 32'h6);
    @(negedge clk);

    // LH / LHU upper half of 0xFFEE0000.
    launch(1'b1, 1'b0, F3_H, 32'h202, 32'h0);
    zero_wait(32'hFFEE0000);
    check_vec("lh_rdata", rdata, 32'hFFFFFFEE);
    @(negedge clk);
    launch(1'b1, 1'b0, F3_HU, 32'h202, 32'h0);
    zero_wait(32'hFFEE0000);
    check_vec("lhu_rdata", rdata, 32'h0000FFEE);
    @(negedge clk);

    // Ready with no request is ignored.
    bus_ready = 1'b1;
    bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    bus_ready = 1'b0;
    check_vec("idle_ready", {done, busy}, 32'h0);
    check_vec("idle_rdata", rdata, 32'h0000FFEE);

    // LW with five wait cycles: done lands at cycle 7.
    launch(1'b1, 1'b0, F3_W, 32'h300, 32'h0);
    bus_rdata = 32'hBADBADBA;
    for (int i = 1; i <= 5; i++) begin
      check_vec("lw_wait_req", {bus_req, busy, done}, 32'h6);
      check_vec("lw_wait_addr", bus_addr, 32'h300);
      check_vec("lw_wait_be", {28'h0, bus_be}, 32'hF);
      @(negedge clk);
    end
    check_vec("lw_c6_req", bus_req, 32'h1);
    zero_wait(32'h12345678);
    check_vec("lw_done", {done, err}, 32'h2);
    check_vec("lw_rdata", rdata, 32'h12345678);
    @(negedge clk);

    // Asynchronous reset mid-BUS.
    launch(1'b1, 1'b0, F3_W, 32'h400, 32'h0);
    check_vec("rstbus_req", bus_req, 32'h1);
    #2 reset = 1'b1;
    #1;
    check_vec("rstbus_drop", {bus_req, busy, done}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    check_vec("rstbus_nodone", done, 32'h0);
    @(negedge clk);
    check_vec("rstbus_idle", {done, bus_req, busy}, 32'h0);

`ifdef LSU_TIMEOUT_EN
    launch(1'b1, 1'b0, F3_W, 32'h600, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      check_vec("to_wait", {bus_req, done}, 32'h2);
      @(negedge clk);
    end
    check_vec("to_fail", {done, err, bus_req}, 32'h6);
    @(negedge clk);
    check_vec("to_pulse", {done, err}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
